// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the programmable sequence detector.
//   - Default configuration applied at reset. It reproduces the fixed 4-bit
//     "1010" overlapping detector that this block replaces.
//   - len_w(): width of a field that holds a length from 0 to max_len.
//   - fill_state_e: classifies how much history the detector holds.
package seq_det_pkg;

    localparam logic [3:0] DEF_PATTERN_LO = 4'b1010;
    localparam int         DEF_LEN        = 4;
    localparam logic       DEF_OVERLAP    = 1'b1;

    // EMPTY   : no history bits are held
    // PARTIAL : some history is held, but not enough for a match
    // PRIMED  : enough history is held that the next accepted bit can match
    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        PRIMED
    } fill_state_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with a synchronous clear.
//   clk, rst_n : clock, and an asynchronous active-low reset to 0
//   inc        : count one event; the count holds at all-ones
//   clr        : load 0, or load 1 when inc is also set, so a coincident
//                event is not lost
//   cnt        : current count (registered)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial bit-pattern detector.
//   cfg_load, cfg_pattern, cfg_len, cfg_overlap : load a new pattern. The
//       MSB of the active length is received first. The load is rejected
//       when cfg_len is 0 or greater than MAX_LEN.
//   cfg_err   : registered one-cycle pulse after a rejected load
//   in_valid, x : serial input bit and its qualifier
//   z         : combinational Mealy match flag, raised in the same cycle
//               as the final pattern bit
//   cnt_clr, match_cnt : synchronous clear, and the saturating count of z
//
// Input semantics: a bit is accepted on a rising edge only when
// in_valid=1 and cfg_load=0. There is no back-pressure. Cycles where
// in_valid=0 leave all detector state untouched.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               in_valid,
    input  logic               x,
    output logic               z,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   match_cnt
);

    typedef logic [MAX_LEN-1:0] pat_t;
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] window;
    logic               primed;
    logic               match;
    logic               cfg_legal;
    fill_state_e        fill_state;

    // Sets bits [len-1:0]. This restricts the compare to the active pattern.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    // Compare path: uses registered state and live inputs only.
    // len_q is never 0, so len_q-1 cannot underflow.
    assign window    = {hist_q, x};
    assign primed    = (fill_q >= (len_q - LEN_W'(1)));
    assign match     = (((window ^ pattern_q) & len_mask(len_q)) == '0) && primed;
    assign z         = in_valid && !cfg_load && match;
    assign cfg_legal = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);

    always_comb begin
        if (primed) begin
            fill_state = PRIMED;
        end else if (fill_q == '0) begin
            fill_state = EMPTY;
        end else begin
            fill_state = PARTIAL;
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cfg_err_d = 1'b0;
        if (cfg_load) begin
            // The serial bit in a load cycle is always dropped.
            if (cfg_legal) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                fill_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d = {hist_q[MAX_LEN-3:0], x};
            if (z && !overlap_q) begin
                // Restart the fill so that no bit of this match is reused.
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= pat_t'(DEF_PATTERN_LO);
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // A match can only occur once enough history is held.
    always_ff @(posedge clk) begin
        if (z) begin
            assert (fill_state == PRIMED);
        end
    end

    assign cfg_err = cfg_err_q;

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (z),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog (MAX_LEN=8, CNT_W=2).
// Inputs change on the falling edge. Outputs are checked 1 ns later.
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_err;
    logic               in_valid;
    logic               x;
    logic               z;
    logic               cnt_clr;
    logic [CNT_W-1:0]   match_cnt;

    int checks   = 0;
    int failures = 0;

    seq_det_prog #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .x          (x),
        .z          (z),
        .cnt_clr    (cnt_clr),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of serial input; z is checked in the same cycle.
    task automatic bit_in(input logic v, input logic b, input logic clr,
                          input logic exp_z, input string tag);
        @(negedge clk);
        cfg_load = 1'b0;
        in_valid = v;
        x        = b;
        cnt_clr  = clr;
        #1;
        chk(16'(z), 16'(exp_z), tag);
    endtask

    // Load cycle with a valid x=1 that must be discarded (z stays 0).
    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ovl, input string tag);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_valid    = 1'b1;
        x           = 1'b1;
        cnt_clr     = 1'b0;
        #1;
        chk(16'(z), 16'h0, tag);
    endtask

    // Sends n bits, MSB first; exp holds the expected z for each bit.
    task automatic run_stream(input logic [15:0] bits, input int n,
                              input logic [15:0] exp, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(1'b1, bits[i], 1'b0, exp[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        x           = 1'b0;
        cnt_clr     = 1'b0;

        // Reset state
        #12;
        chk(16'(z), 16'h0, "rst_z");
        chk(16'(cfg_err), 16'h0, "rst_cfg_err");
        chk(16'(match_cnt), 16'h0, "rst_cnt");
        @(negedge clk);
        rst_n = 1'b1;

        // Default 1010 with overlap: z on bits 4 and 6
        run_stream(16'b101010, 6, 16'b000101, "def_ovl");
        bit_in(1'b0, 1'b0, 1'b0, 1'b0, "def_idle");
        chk(16'(match_cnt), 16'd2, "def_cnt2");
        bit_in(1'b0, 1'b0, 1'b1, 1'b0, "clr1");
        bit_in(1'b0, 1'b0, 1'b0, 1'b0, "clr1_idle");
        chk(16'(match_cnt), 16'd0, "clr1_cnt0");

        // 110 / len 3 / non-overlap: z on bits 3 and 6
        load(8'b110, 4'd3, 1'b0, "ld_110");
        run_stream(16'b11011010, 8, 16'b00100100, "p110");

        // 1010 non-overlap: z on bits 4 and 8 only
        load(8'b1010, 4'd4, 1'b0, "ld_1010_novl");
        run_stream(16'b10101010, 8, 16'b00010001, "novl");

        // in_valid gaps with random x on the idle cycles
        load(8'b1010, 4'd4, 1'b1, "ld_1010_ovl");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "gap_v1");
        bit_in(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "gap_i1");
        bit_in(1'b1, 1'b0, 1'b0, 1'b0, "gap_v2");
        bit_in(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "gap_i2");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "gap_v3");
        bit_in(1'b0, 1'b0, 1'b0, 1'b0, "gap_i3");
        bit_in(1'b1, 1'b0, 1'b0, 1'b1, "gap_v4");

        // len 1, pattern 1: z on bits 1, 2, 4
        load(8'b1, 4'd1, 1'b1, "ld_len1");
        run_stream(16'b1101, 4, 16'b1101, "len1");

        // Illegal lengths: cfg_err pulse; config is kept
        load(8'b0, 4'd0, 1'b0, "ld_len0");
        chk(16'(cfg_err), 16'h0, "len0_err_pre");
        bit_in(1'b1, 1'b1, 1'b0, 1'b1, "len0_keep");
        chk(16'(cfg_err), 16'h1, "len0_err");
        bit_in(1'b0, 1'b0, 1'b0, 1'b0, "len0_idle");
        chk(16'(cfg_err), 16'h0, "len0_err_end");
        load(8'b0, 4'd9, 1'b0, "ld_len9");
        bit_in(1'b1, 1'b1, 1'b0, 1'b1, "len9_keep");
        chk(16'(cfg_err), 16'h1, "len9_err");

        // Counter saturation at 3, then clear coincident with a match
        bit_in(1'b0, 1'b0, 1'b1, 1'b0, "clr2");
        for (int i = 0; i < 8; i++) begin
            bit_in(1'b1, 1'b1, 1'b0, 1'b1, $sformatf("sat_b%0d", i + 1));
        end
        bit_in(1'b0, 1'b0, 1'b0, 1'b0, "sat_idle");
        chk(16'(match_cnt), 16'd3, "sat_cnt3");
        bit_in(1'b1, 1'b1, 1'b1, 1'b1, "clr_match");
        bit_in(1'b0, 1'b0, 1'b0, 1'b0, "clr_match_idle");
        chk(16'(match_cnt), 16'd1, "clr_match_cnt1");

        // Reset mid-stream after 1,0,1: the final 0 must not match
        load(8'b1010, 4'd4, 1'b1, "ld_rst");
        run_stream(16'b101, 3, 16'b000, "pre_rst");
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        x        = 1'b0;
        #1;
        chk(16'(z), 16'h0, "in_rst_z");
        chk(16'(match_cnt), 16'h0, "in_rst_cnt");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        bit_in(1'b1, 1'b0, 1'b0, 1'b0, "post_rst_0");

        // A custom config is replaced by the 1010 overlap default on reset
        load(8'b1111_0000, 4'd8, 1'b0, "ld_custom");
        @(negedge clk);
        in_valid = 1'b0;
        cfg_load = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(16'b101010, 6, 16'b000101, "def_again");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
